// File: rtl/vlsu_ar_gen_pkg.sv
// Shared types and constants for the VLSU read-address generator.
// Holds bus geometry, AXI limits, the request/burst payload structs, the
// FSM state type, and small helpers for request validation and segment size.
package vlsu_ar_gen_pkg;

    localparam int unsigned busBytes       = 64;
    localparam int unsigned addrBits       = 32;
    localparam int unsigned cntBits        = 16;
    localparam int unsigned rowBits        = 16;
    localparam int unsigned lenBits        = 8;
    localparam int unsigned busOffBits     = $clog2(busBytes);
    localparam int unsigned AXI_MAX_BEATS  = 256;
    localparam int unsigned AXI_PAGE_BYTES = 4096;
    localparam int unsigned pageBits       = $clog2(AXI_PAGE_BYTES);
    // Segment byte counter: cnt << 3 needs cntBits+3, plus one spare bit.
    localparam int unsigned segBits        = cntBits + 3 + 1;
    localparam int unsigned maxBurstBytes  = AXI_MAX_BEATS * busBytes;

    // One-hot request mode.
    typedef logic [3:0] mode_oh_t;
    localparam mode_oh_t MODE_INCR  = 4'b0001;
    localparam mode_oh_t MODE_STRD  = 4'b0010;
    localparam mode_oh_t MODE_CLN2D = 4'b0100;
    localparam mode_oh_t MODE_ROW2D = 4'b1000;

    typedef struct packed {
        mode_oh_t              mode;
        logic [addrBits-1:0]   base;
        logic [addrBits-1:0]   stride;
        logic [cntBits-1:0]    cnt;
        logic [1:0]            esize;
        logic [rowBits-1:0]    row_bytes;
    } vlsu_ar_req_t;

    typedef struct packed {
        logic [addrBits-1:0]   addr;
        logic [lenBits-1:0]    len;
        logic                  last;
    } vlsu_ar_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        ISSUE
    } ar_gen_state_e;

    // True when exactly one mode bit is set.
    function automatic logic is_onehot(input mode_oh_t mode);
        return (mode != '0) && ((mode & mode_oh_t'(mode - 4'd1)) == '0);
    endfunction

    // Byte size of every segment of a request.
    function automatic logic [segBits-1:0] seg_bytes(input vlsu_ar_req_t req);
        logic [segBits-1:0] size;
        if (req.mode == MODE_INCR) begin
            size = segBits'(req.cnt) << req.esize;
        end else if (req.mode == MODE_ROW2D) begin
            size = segBits'(req.row_bytes);
        end else begin
            size = segBits'(1) << req.esize;
        end
        return size;
    endfunction

endpackage

// File: rtl/vlsu_ar_gen_if.sv
// Request and AR-channel bundle of the VLSU read-address generator.
// master: request producer / AR consumer side. slave: the generator itself.
// Signals: req_* (request handshake + fields), ar_* (AXI AR channel),
// err_o (reject pulse), busy_o (FSM not idle).
interface vlsu_ar_gen_if;
    import vlsu_ar_gen_pkg::*;

    logic                  req_valid_i;
    logic                  req_ready_o;
    mode_oh_t              req_mode_i;
    logic [addrBits-1:0]   req_base_i;
    logic [addrBits-1:0]   req_stride_i;
    logic [cntBits-1:0]    req_cnt_i;
    logic [1:0]            req_esize_i;
    logic [rowBits-1:0]    req_row_bytes_i;

    logic                  ar_valid_o;
    logic                  ar_ready_i;
    logic [addrBits-1:0]   ar_addr_o;
    logic [lenBits-1:0]    ar_len_o;
    logic [2:0]            ar_size_o;
    logic [1:0]            ar_burst_o;
    logic                  ar_last_o;

    logic                  err_o;
    logic                  busy_o;

    modport master (
        output req_valid_i, req_mode_i, req_base_i, req_stride_i,
               req_cnt_i, req_esize_i, req_row_bytes_i, ar_ready_i,
        input  req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o,
               ar_burst_o, ar_last_o, err_o, busy_o
    );

    modport slave (
        input  req_valid_i, req_mode_i, req_base_i, req_stride_i,
               req_cnt_i, req_esize_i, req_row_bytes_i, ar_ready_i,
        output req_ready_o, ar_valid_o, ar_addr_o, ar_len_o, ar_size_o,
               ar_burst_o, ar_last_o, err_o, busy_o
    );

endinterface

// File: rtl/vlsu_ar_gen_burst_calc.sv
// Combinational burst sizing for one AR burst.
// Build option: VLSU_AR_SPLIT_4K_EN also limits bursts at 4 KiB page ends.
// Ports:
//   i_addr_lo  low page-offset bits of the burst start address
//   i_seg_rem  bytes still to fetch in the current segment
//   o_bytes_c  bytes covered by this burst
//   o_len_c    AXI len (beats - 1) for this burst
module vlsu_ar_gen_burst_calc
    import vlsu_ar_gen_pkg::*;
(
    input  logic [pageBits-1:0] i_addr_lo,
    input  logic [segBits-1:0]  i_seg_rem,
    output logic [segBits-1:0]  o_bytes_c,
    output logic [lenBits-1:0]  o_len_c
);

    logic [segBits-1:0] w_off;
    logic [segBits-1:0] w_lim;
    logic [segBits-1:0] w_end;
    logic [segBits-1:0] w_beats;
`ifdef VLSU_AR_SPLIT_4K_EN
    logic [segBits-1:0] w_page_rem;
`else
    logic               w_unused_page;
`endif

    // Burst bytes = min(segment remainder, 256-beat limit [, page remainder]).
    always_comb begin
        w_off = segBits'(i_addr_lo[busOffBits-1:0]);
        w_lim = segBits'(maxBurstBytes) - w_off;
`ifdef VLSU_AR_SPLIT_4K_EN
        w_page_rem = segBits'(AXI_PAGE_BYTES) - segBits'(i_addr_lo);
        if (w_page_rem < w_lim) begin
            w_lim = w_page_rem;
        end
`else
        w_unused_page = ^i_addr_lo[pageBits-1:busOffBits];
`endif
        o_bytes_c = (i_seg_rem < w_lim) ? i_seg_rem : w_lim;
        // Beats cover the unaligned head offset too; len = beats - 1.
        w_end   = w_off + o_bytes_c;
        w_beats = (w_end + segBits'(busBytes - 1)) >> busOffBits;
        o_len_c = lenBits'(w_beats - segBits'(1));
    end

endmodule

// File: rtl/vlsu_ar_gen.sv
// VLSU read-path address generator: splits one INCR/STRD/CLN2D/ROW2D vector
// request into AXI INCR read bursts on the data bus.
// Build option: VLSU_AR_SPLIT_4K_EN keeps bursts inside 4 KiB pages.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   bus            vlsu_ar_gen_if.slave: request handshake, AR channel,
//                  err_o reject pulse, busy_o
module vlsu_ar_gen
    import vlsu_ar_gen_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    vlsu_ar_gen_if.slave  bus
);

    ar_gen_state_e       r_state;
    // r_req.base doubles as the running segment base once latched.
    vlsu_ar_req_t        r_req;
    logic [addrBits-1:0] r_addr;
    logic [segBits-1:0]  r_seg_rem;
    logic [segBits-1:0]  r_bytes;
    logic [cntBits-1:0]  r_seg_idx;
    vlsu_ar_t            r_ar;
    logic                r_ar_valid;
    logic                r_req_ready;
    logic                r_err;
    logic                r_busy;

    vlsu_ar_req_t        w_req;
    logic                w_req_hs;
    logic                w_req_bad;
    logic                w_last_seg;
    logic                w_ar_hs;
    logic [segBits-1:0]  w_bytes;
    logic [segBits-1:0]  w_rem_nxt;
    logic [addrBits-1:0] w_seg_base_nxt;
    logic [lenBits-1:0]  w_len;

    assign w_req = '{
        mode:      bus.req_mode_i,
        base:      bus.req_base_i,
        stride:    bus.req_stride_i,
        cnt:       bus.req_cnt_i,
        esize:     bus.req_esize_i,
        row_bytes: bus.req_row_bytes_i
    };

    assign w_req_hs  = bus.req_valid_i & r_req_ready;
    assign w_req_bad = !is_onehot(w_req.mode) || (w_req.cnt == '0) ||
                       ((w_req.mode == MODE_ROW2D) && (w_req.row_bytes == '0));
    // INCR is a single segment; the others have cnt segments.
    assign w_last_seg = (r_req.mode == MODE_INCR) ||
                        (r_seg_idx == cntBits'(r_req.cnt - cntBits'(1)));
    assign w_ar_hs        = r_ar_valid & bus.ar_ready_i;
    assign w_rem_nxt      = r_seg_rem - r_bytes;
    assign w_seg_base_nxt = r_req.base + r_req.stride;

    vlsu_ar_gen_burst_calc u_burst_calc (
        .i_addr_lo (r_addr[pageBits-1:0]),
        .i_seg_rem (r_seg_rem),
        .o_bytes_c (w_bytes),
        .o_len_c   (w_len)
    );

    // Request latch, burst sequencing and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= IDLE;
            r_req       <= '0;
            r_addr      <= '0;
            r_seg_rem   <= '0;
            r_bytes     <= '0;
            r_seg_idx   <= '0;
            r_ar        <= '0;
            r_ar_valid  <= 1'b0;
            r_req_ready <= 1'b1;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_req_hs) begin
                        if (w_req_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_req       <= w_req;
                            r_addr      <= w_req.base;
                            r_seg_rem   <= seg_bytes(w_req);
                            r_seg_idx   <= '0;
                            r_req_ready <= 1'b0;
                            r_busy      <= 1'b1;
                            r_state     <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_ar.addr  <= r_addr;
                    r_ar.len   <= w_len;
                    r_ar.last  <= (w_bytes == r_seg_rem) && w_last_seg;
                    r_bytes    <= w_bytes;
                    r_ar_valid <= 1'b1;
                    r_state    <= ISSUE;
                end
                ISSUE: begin
                    if (w_ar_hs) begin
                        r_ar_valid <= 1'b0;
                        if (w_rem_nxt != '0) begin
                            r_addr    <= r_addr + addrBits'(r_bytes);
                            r_seg_rem <= w_rem_nxt;
                            r_state   <= CALC;
                        end else if (w_last_seg) begin
                            r_seg_rem   <= '0;
                            r_req_ready <= 1'b1;
                            r_busy      <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_req.base <= w_seg_base_nxt;
                            r_addr     <= w_seg_base_nxt;
                            r_seg_rem  <= seg_bytes(r_req);
                            r_seg_idx  <= r_seg_idx + cntBits'(1);
                            r_state    <= CALC;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready_o = r_req_ready;
    assign bus.ar_valid_o  = r_ar_valid;
    assign bus.ar_addr_o   = r_ar.addr;
    assign bus.ar_len_o    = r_ar.len;
    assign bus.ar_last_o   = r_ar.last;
    assign bus.ar_size_o   = 3'(busOffBits);
    assign bus.ar_burst_o  = 2'b01;
    assign bus.err_o       = r_err;
    assign bus.busy_o      = r_busy;

endmodule

// File: tb/tb_vlsu_ar_gen.sv
// Randomized self-checking bench for vlsu_ar_gen against a burst-list model.
module tb_vlsu_ar_gen;
    import vlsu_ar_gen_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    vlsu_ar_gen_if bus ();

    vlsu_ar_gen dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned exp_addr[$];
    int unsigned exp_len[$];
    bit          exp_last[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Expected burst list, straight from the segment/burst rules on a 64 B bus.
    task automatic build_exp(input logic [3:0] mode, input int unsigned base,
                             input int unsigned stride, input int unsigned cnt,
                             input int unsigned esize, input int unsigned row);
        int unsigned nseg, segsz, a, rem, off, lim, b;
        exp_addr.delete();
        exp_len.delete();
        exp_last.delete();
        if (mode == MODE_INCR) begin
            nseg = 1;
            segsz = cnt << esize;
        end else begin
            nseg = cnt;
            segsz = (mode == MODE_ROW2D) ? row : (1 << esize);
        end
        for (int unsigned s = 0; s < nseg; s++) begin
            a = base + s * stride;
            rem = segsz;
            while (rem != 0) begin
                off = a % 64;
                lim = 256 * 64 - off;
`ifdef VLSU_AR_SPLIT_4K_EN
                if (4096 - (a % 4096) < lim) lim = 4096 - (a % 4096);
`endif
                b = (rem < lim) ? rem : lim;
                exp_addr.push_back(a);
                exp_len.push_back((off + b + 63) / 64 - 1);
                exp_last.push_back((rem == b) && (s == nseg - 1));
                a = a + b;
                rem = rem - b;
            end
        end
    endtask

    task automatic drive_req(input logic [3:0] mode, input int unsigned base,
                             input int unsigned stride, input int unsigned cnt,
                             input int unsigned esize, input int unsigned row);
        bus.req_valid_i     = 1'b1;
        bus.req_mode_i      = mode;
        bus.req_base_i      = base;
        bus.req_stride_i    = stride;
        bus.req_cnt_i       = 16'(cnt);
        bus.req_esize_i     = 2'(esize);
        bus.req_row_bytes_i = 16'(row);
    endtask

    // Issue one legal request and check every AR burst it produces.
    task automatic run_req(input string tag, input logic [3:0] mode,
                           input int unsigned base, input int unsigned stride,
                           input int unsigned cnt, input int unsigned esize,
                           input int unsigned row, input int ready_pct, input int hold);
        int cyc, idx, held;
        bit done, seen;
        build_exp(mode, base, stride, cnt, esize, row);
        @(negedge clk_i);
        drive_req(mode, base, stride, cnt, esize, row);
        chk({tag, ".req_ready"}, bus.req_ready_o, 1);
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        cyc = 1; idx = 0; held = 0; done = 0; seen = 0;
        while (!done && cyc < 2000) begin
            chk({tag, ".ready_low"}, bus.req_ready_o, 0);
            if (bus.ar_valid_o) begin
                if (!seen) begin
                    seen = 1;
                    chk({tag, ".latency"}, cyc, 2);
                end
                if (held < hold) begin
                    bus.ar_ready_i = 1'b0;
                    held++;
                    chk({tag, ".hold_addr"}, bus.ar_addr_o, exp_addr[idx]);
                    chk({tag, ".hold_len"}, bus.ar_len_o, exp_len[idx]);
                end else begin
                    bus.ar_ready_i = ($urandom_range(99) < ready_pct);
                    if (bus.ar_ready_i) begin
                        chk({tag, ".addr"}, bus.ar_addr_o, exp_addr[idx]);
                        chk({tag, ".len"}, bus.ar_len_o, exp_len[idx]);
                        chk({tag, ".last"}, bus.ar_last_o, exp_last[idx]);
                        idx++;
                        if (idx == exp_addr.size()) done = 1;
                    end
                end
            end else begin
                bus.ar_ready_i = 1'($urandom_range(1));
            end
            @(negedge clk_i);
            cyc++;
        end
        bus.ar_ready_i = 1'b0;
        if (!done) chk({tag, ".timeout_bursts"}, idx, exp_addr.size());
        chk({tag, ".end_ready"}, bus.req_ready_o, 1);
        chk({tag, ".end_busy"}, bus.busy_o, 0);
        chk({tag, ".end_valid"}, bus.ar_valid_o, 0);
    endtask

    // Issue an illegal request: one err pulse, no AR, ready stays high.
    task automatic run_bad(input string tag, input logic [3:0] mode,
                           input int unsigned cnt, input int unsigned row);
        int errs;
        @(negedge clk_i);
        drive_req(mode, $urandom, $urandom, cnt, $urandom_range(3), row);
        chk({tag, ".req_ready"}, bus.req_ready_o, 1);
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            bus.req_valid_i = 1'b0;
            if (bus.err_o === 1'b1) errs++;
            chk({tag, ".no_ar"}, bus.ar_valid_o, 0);
            chk({tag, ".ready_hi"}, bus.req_ready_o, 1);
        end
        chk({tag, ".err_cycles"}, errs, 1);
    endtask

    task automatic run_reset_mid;
        int w;
        @(negedge clk_i);
        drive_req(MODE_STRD, 'h100, 'h200, 3, 3, 0);
        @(negedge clk_i);
        bus.req_valid_i = 1'b0;
        bus.ar_ready_i  = 1'b0;
        w = 0;
        while (!bus.ar_valid_o && w < 10) begin
            @(negedge clk_i);
            w++;
        end
        chk("rst.reached_issue", bus.ar_valid_o, 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst.valid_async", bus.ar_valid_o, 0);
        chk("rst.busy", bus.busy_o, 0);
        chk("rst.ready", bus.req_ready_o, 1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst.idle_ready", bus.req_ready_o, 1);
        chk("rst.idle_busy", bus.busy_o, 0);
        chk("rst.idle_valid", bus.ar_valid_o, 0);
        chk("rst.idle_addr", bus.ar_addr_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mode, badm;
        int unsigned cnt, row;
        bus.req_valid_i = 1'b0;
        bus.ar_ready_i  = 1'b0;
        drive_req(MODE_INCR, 0, 0, 0, 0, 0);
        bus.req_valid_i = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("reset.req_ready", bus.req_ready_o, 1);
        chk("reset.ar_valid", bus.ar_valid_o, 0);
        chk("reset.ar_last", bus.ar_last_o, 0);
        chk("reset.err", bus.err_o, 0);
        chk("reset.busy", bus.busy_o, 0);
        chk("reset.ar_addr", bus.ar_addr_o, 0);
        chk("reset.ar_len", bus.ar_len_o, 0);
        chk("reset.ar_size", bus.ar_size_o, 6);
        chk("reset.ar_burst", bus.ar_burst_o, 1);
        rst_ni = 1'b1;
        @(negedge clk_i);

        run_req("incr256", MODE_INCR, 'h1000, 0, 64, 2, 0, 100, 0);
        run_req("incr_page", MODE_INCR, 'h0FC0, 0, 32, 2, 0, 100, 0);
        run_req("incr32k", MODE_INCR, 0, 0, 8192, 2, 0, 100, 0);
        run_req("strd", MODE_STRD, 'h100, 'h200, 3, 3, 0, 100, 0);
        run_req("row2d", MODE_ROW2D, 'h2010, 'h400, 2, 0, 128, 100, 0);
        run_req("cln2d_wrap", MODE_CLN2D, 'hFFFF_FFF8, 'h10, 3, 3, 0, 100, 0);

        run_bad("bad_mode", 4'b0011, 4, 16);
        run_bad("bad_cnt", MODE_INCR, 0, 16);
        run_bad("bad_row", MODE_ROW2D, 2, 0);

        run_req("backpressure", MODE_STRD, 'h100, 'h200, 3, 3, 0, 100, 5);
        run_reset_mid();
        run_req("post_reset", MODE_STRD, 'h100, 'h200, 3, 3, 0, 100, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(7) == 0) begin
                badm = 4'($urandom_range(15));
                while ($countones(badm) == 1) badm = 4'($urandom_range(15));
                run_bad("rnd_bad", badm, $urandom_range(1, 9), $urandom_range(1, 99));
            end else begin
                case ($urandom_range(3))
                    0: mode = MODE_INCR;
                    1: mode = MODE_STRD;
                    2: mode = MODE_CLN2D;
                    default: mode = MODE_ROW2D;
                endcase
                cnt = (mode == MODE_INCR) ? $urandom_range(1, 4096) : $urandom_range(1, 6);
                row = ($urandom_range(4) == 0) ? $urandom_range(16000, 40000)
                                               : $urandom_range(1, 3000);
                run_req("rnd", mode, $urandom, $urandom, cnt, $urandom_range(3),
                        row, 60, $urandom_range(2));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vlsu_ar_gen.md
Name: vlsu_ar_gen

Overview:
Address-generation front stage of the VLSU read path. Accepts one vector memory request in one of four modes: incremental, strided, row-major 2D, or column-major 2D. Breaks the request into AXI read-address bursts on the busBits-wide data bus. Sits between the vector instruction decoder and the AXI AR channel; its bursts feed the transaction controllers and meta buffer.

Parameters:
- BUS_BYTES, vlsu_pkg::busBytes (64): data bus width in bytes.
- ADDR_BITS, vlsu_pkg::addrBits (32): address width.
- CNT_BITS, 16: width of the element/row count field.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_mode_i  in  4  mode_oh_t, must be one-hot
- req_base_i  in  ADDR_BITS  start byte address
- req_stride_i  in  ADDR_BITS  byte stride between segments (STRD/CLN2D/ROW2D)
- req_cnt_i  in  CNT_BITS  element count (INCR/STRD/CLN2D) or row count (ROW2D)
- req_esize_i  in  2  log2 element bytes (1/2/4/8)
- req_row_bytes_i  in  16  bytes per row (ROW2D only)
- ar_valid_o  out  1  burst valid
- ar_ready_i  in  1  burst accepted
- ar_addr_o  out  ADDR_BITS  burst start byte address (unaligned allowed)
- ar_len_o  out  8  beats-1
- ar_size_o  out  3  constant log2(BUS_BYTES)
- ar_burst_o  out  2  constant 2'b01 (INCR)
- ar_last_o  out  1  final burst of current request
- err_o  out  1  one-cycle pulse: request rejected
- busy_o  out  1  FSM not IDLE

Behaviour:
- Reset: FSM=IDLE. req_ready_o=1; ar_valid_o, ar_last_o, err_o, busy_o =0. ar_addr_o and ar_len_o =0. ar_size_o and ar_burst_o are constants.
- Reset asserted mid-operation aborts the request. ar_valid_o drops asynchronously, and the partially issued request is discarded.
- Segment definition:
  - INCR: one segment, cnt<<esize bytes, at base.
  - STRD and CLN2D: cnt segments of 1<<esize bytes, segment i at base+i*stride.
  - ROW2D: cnt segments of row_bytes bytes, segment i at base+i*stride.
- Segment byte counter is 20 bits (CNT_BITS+3+1). Address arithmetic wraps modulo 2^ADDR_BITS.
- FSM states:
  - IDLE: req_ready_o=1. On handshake, latch all fields. Reject (err_o pulse next cycle, stay IDLE, no AR) if the mode is not one-hot, cnt==0, or ROW2D with row_bytes==0. Otherwise go to CALC.
  - CALC (1 cycle): with off = addr%BUS_BYTES, compute:
    - burst bytes = min(seg_rem, 256*BUS_BYTES-off, 4096-addr%4096 [see optional feature]);
    - ar_len = ceil((off+bytes)/BUS_BYTES)-1;
    - ar_last = (bytes==seg_rem) && last segment.
    Register these into the AR outputs, then go to ISSUE.
  - ISSUE: ar_valid_o=1. AR outputs are held stable while ar_ready_i=0. On handshake:
    - seg_rem -= bytes; addr += bytes.
    - If seg_rem==0 and last segment, go to IDLE.
    - If seg_rem==0 and not last, seg_base += stride, addr=seg_base, seg_rem=segment size, go to CALC.
    - Otherwise go to CALC.
- Latency: request handshake to first ar_valid_o = 2 cycles. Peak throughput is 1 burst per 2 cycles.
- req_ready_o=0 outside IDLE. A new request is accepted in the cycle after the last AR handshake.
- busy_o=1 in CALC and ISSUE.

Optional Feature:
VLSU_AR_SPLIT_4K_EN
- Defined: bursts never cross a 4 KiB boundary; the 4096-addr%4096 term is included in the min (AXI-compliant).
- Undefined: that term is omitted; bursts are limited only by 256 beats and segment size. This is for non-AXI-strict fabrics.

Decomposition:
- vlsu_pkg additions:
  - AXI_MAX_BEATS=256, AXI_PAGE_BYTES=4096, busOffBits=$clog2(busBytes);
  - vlsu_ar_req_t struct (mode, base, stride, cnt, esize, row_bytes);
  - vlsu_ar_t struct (addr, len, last);
  - ar_gen_state_e enum {IDLE, CALC, ISSUE}.
- One natural sub-module: vlsu_burst_calc, the combinational burst-size/len computation used in CALC.

Test Plan:
All cases use BUS_BYTES=64.
- INCR, base 0x1000, esize 2, cnt 64 (256 B) -> one AR: addr 0x1000, len 3, last=1.
- INCR, base 0x0FC0, esize 2, cnt 32 (128 B):
  - with _EN -> AR 0x0FC0 len 0, then AR 0x1000 len 0 last;
  - without -> single AR 0x0FC0 len 1 last.
- INCR, base 0x0, esize 2, cnt 8192 (32 KiB):
  - with _EN -> 8 ARs of len 63, addr step 0x1000;
  - without -> 2 ARs of len 255 at 0x0 and 0x4000.
- STRD, base 0x100, stride 0x200, esize 3, cnt 3 -> ARs 0x100, 0x300, 0x500, each len 0; last only on third.
- ROW2D, base 0x2010, row_bytes 128, stride 0x400, cnt 2 -> AR 0x2010 len 2, then AR 0x2410 len 2 last.
- Each of the following -> err_o high exactly 1 cycle, no ar_valid_o, req_ready_o=1 throughout:
  - mode 4'b0011;
  - cnt 0;
  - ROW2D with row_bytes 0.
- Backpressure and reset, on the case-4 request:
  - hold ar_ready_i=0 for 5 cycles -> ar_addr_o/ar_len_o stable, req_ready_o=0 throughout;
  - assert rst_ni low mid-ISSUE -> ar_valid_o=0 immediately, IDLE after release.
